// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe from a clock divider, h/v position counters,
// sync pulses, active-video flag and a once-per-frame pulse, all from flops.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          HS,
  output logic          VS,
  output logic          video_on,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic [CW-1:0] hcount_q, hcount_d;
  logic [CW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          video_on_q, video_on_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    pix_en_d = (div_q == DIV_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
    // Decode from the next position so the flags land with the counters.
    hs_d          = (hcount_d >= HS_START && hcount_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d          = (vcount_d >= VS_START && vcount_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    frame_start_d = pix_en_q && (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two shrunken rasters
// (divided and undivided, opposite sync polarity) checked against a cycle model.
module tb_vga_timing_gen;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pe_d, hs_d, vs_d, von_d, fs_d;
  logic [9:0] hc_d, vc_d;
  logic       pe_s, hs_s, vs_s, von_s, fs_s;
  logic [5:0] hc_s, vc_s;
  logic       pe_o, hs_o, vs_o, von_o, fs_o;
  logic [5:0] hc_o, vc_o;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pix_en(pe_d), .hcount(hc_d), .vcount(vc_d),
    .HS(hs_d), .VS(vs_d), .video_on(von_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .CW(6)
  ) u_sml (
    .clk(clk), .rst(rst), .pix_en(pe_s), .hcount(hc_s), .vcount(vc_s),
    .HS(hs_s), .VS(vs_s), .video_on(von_s), .frame_start(fs_s)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1), .CW(6)
  ) u_one (
    .clk(clk), .rst(rst), .pix_en(pe_o), .hcount(hc_o), .vcount(vc_o),
    .HS(hs_o), .VS(vs_o), .video_on(von_o), .frame_start(fs_o)
  );

  typedef struct {
    int clk_div; int h_act; int h_fp; int h_sync; int h_bp;
    int v_act; int v_fp; int v_sync; int v_bp; bit pol;
  } cfg_t;

  typedef struct {
    int div; bit pix_en; int h; int v; bit hs; bit vs; bit von; bit fs;
  } st_t;

  function automatic st_t step(st_t s, bit r, cfg_t c);
    st_t n;
    int ht = c.h_act + c.h_fp + c.h_sync + c.h_bp;
    int vt = c.v_act + c.v_fp + c.v_sync + c.v_bp;
    n = s;
    if (r) begin
      n.div = 0; n.pix_en = 0; n.h = ht - 1; n.v = vt - 1;
      n.hs = !c.pol; n.vs = !c.pol; n.von = 0; n.fs = 0;
      return n;
    end
    n.div    = (s.div + 1) % c.clk_div;
    n.pix_en = (s.div == c.clk_div - 1);
    n.fs     = 0;
    if (s.pix_en) begin
      n.h = (s.h + 1) % ht;
      if (n.h == 0) n.v = (s.v + 1) % vt;
      n.fs = (n.h == 0) && (n.v == 0);
    end
    n.hs  = (n.h >= c.h_act + c.h_fp && n.h < c.h_act + c.h_fp + c.h_sync) ? c.pol : !c.pol;
    n.vs  = (n.v >= c.v_act + c.v_fp && n.v < c.v_act + c.v_fp + c.v_sync) ? c.pol : !c.pol;
    n.von = (n.h < c.h_act) && (n.v < c.v_act);
    return n;
  endfunction

  function automatic logic [W-1:0] pack(st_t s);
    return {7'd0, s.pix_en, 10'(s.h), 10'(s.v), s.hs, s.vs, s.von, s.fs};
  endfunction

  cfg_t cfg_d, cfg_s, cfg_o;
  st_t  st_d, st_s, st_o;
  logic [W-1:0] exp_q_d[$];
  logic [W-1:0] exp_q_s[$];
  logic [W-1:0] exp_q_o[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_since = 0;
  bit collect = 0;

  int n_pe = 0, last_pe = -1;
  int hs_px = 0, hs_min = 9999, hs_max = -1, von_px = 0;
  logic [9:0] prev_h_d = '0;
  int n_fs_s = 0, last_fs_s = -1, vs_bad = 0, vs_seen = 0, von_bad = 0;
  int n_fs_o = 0, last_fs_o = -1, pe_o_bad = 0, hs_o_cyc = 0, vs_o_cyc = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic gather();
    if (cyc_since <= 40 && pe_d) begin
      n_pe++;
      if (last_pe >= 0) check("pe_gap_def", cyc_since - last_pe, 4);
      last_pe = cyc_since;
    end
    if (vc_d == 10'd0 && hc_d != prev_h_d) begin
      if (!hs_d) begin
        hs_px++;
        if (int'(hc_d) < hs_min) hs_min = int'(hc_d);
        if (int'(hc_d) > hs_max) hs_max = int'(hc_d);
      end
      if (von_d) von_px++;
    end
    prev_h_d = hc_d;
    if (fs_s) begin
      n_fs_s++;
      if (last_fs_s >= 0) check("frame_gap_sml", cyc_since - last_fs_s, 1125);
      last_fs_s = cyc_since;
    end
    if ((!vs_s) != (vc_s == 6'd10 || vc_s == 6'd11)) vs_bad++;
    if (!vs_s) vs_seen++;
    if (von_s && vc_s >= 6'd8) von_bad++;
    if (!pe_o) pe_o_bad++;
    if (fs_o) begin
      n_fs_o++;
      if (last_fs_o >= 0) check("frame_gap_one", cyc_since - last_fs_o, 375);
      last_fs_o = cyc_since;
    end
    if (cyc_since <= 376 && vc_o == 6'd0 && hs_o) hs_o_cyc++;
    if (cyc_since <= 376 && vs_o) vs_o_cyc++;
  endtask

  task automatic drive_cycle(input bit r);
    @(negedge clk);
    rst = r;
    st_d = step(st_d, r, cfg_d); exp_q_d.push_back(pack(st_d));
    st_s = step(st_s, r, cfg_s); exp_q_s.push_back(pack(st_s));
    st_o = step(st_o, r, cfg_o); exp_q_o.push_back(pack(st_o));
    @(posedge clk);
    #1;
    cyc_since = r ? 0 : cyc_since + 1;
    check("sb_def", {7'd0, pe_d, hc_d, vc_d, hs_d, vs_d, von_d, fs_d}, exp_q_d.pop_front());
    check("sb_sml", {7'd0, pe_s, 10'(hc_s), 10'(vc_s), hs_s, vs_s, von_s, fs_s}, exp_q_s.pop_front());
    check("sb_one", {7'd0, pe_o, 10'(hc_o), 10'(vc_o), hs_o, vs_o, von_o, fs_o}, exp_q_o.pop_front());
    if (collect) gather();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_h"},  32'(hc_d), 799);
    check({pfx, "_v"},  32'(vc_d), 524);
    check({pfx, "_hs"}, 32'(hs_d), 1);
    check({pfx, "_vs"}, 32'(vs_d), 1);
    check({pfx, "_von"}, 32'(von_d), 0);
    check({pfx, "_pe"}, 32'(pe_d), 0);
    check({pfx, "_fs"}, 32'(fs_d), 0);
  endtask

  initial begin
    int guard;
    int fs_at_d, fs_at_s, fs_at_o;
    cfg_d = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg_s = '{3, 16, 2, 4, 3, 8, 2, 2, 3, 1'b0};
    cfg_o = '{1, 16, 2, 4, 3, 8, 2, 2, 3, 1'b1};

    repeat (3) drive_cycle(1'b1);
    check_reset_values("rst");

    collect = 1'b1;
    repeat (3300) drive_cycle(1'b0);
    collect = 1'b0;

    check("pe_count_40", n_pe, 10);
    check("hs_pixels", hs_px, 96);
    check("hs_first", hs_min, 656);
    check("hs_last", hs_max, 751);
    check("von_pixels", von_px, 640);
    check("fs_count_sml", n_fs_s, 3);
    check("vs_lines_sml", vs_bad, 0);
    check("vs_cycles_sml", vs_seen, 450);
    check("von_blank_sml", von_bad, 0);
    check("pe_const_one", pe_o_bad, 0);
    check("fs_count_one", n_fs_o, 9);
    check("hs_width_one", hs_o_cyc, 4);
    check("vs_width_one", vs_o_cyc, 50);

    guard = 0;
    while (hc_d != 10'd300 && guard < 5000) begin
      drive_cycle(1'b0);
      guard++;
    end
    check("wait_h300", 32'(hc_d), 300);
    drive_cycle(1'b1);
    check_reset_values("mid_rst");

    fs_at_d = -1; fs_at_s = -1; fs_at_o = -1;
    for (int k = 1; k <= 20; k++) begin
      drive_cycle(1'b0);
      if (fs_d && fs_at_d < 0) fs_at_d = k;
      if (fs_s && fs_at_s < 0) fs_at_s = k;
      if (fs_o && fs_at_o < 0) fs_at_o = k;
    end
    check("fs_delay_def", fs_at_d, 5);
    check("fs_delay_sml", fs_at_s, 4);
    check("fs_delay_one", fs_at_o, 2);

    repeat (100) drive_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
